// File: rtl/scan_pkg.sv
// Shared types for the position scanner: travel direction encoding and default width.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package scan_pkg;

  // Direction doubles as the FSM state; one bit, RIGHT means increment.
  typedef enum logic {
    DIR_LEFT  = 1'b0,
    DIR_RIGHT = 1'b1
  } dir_e;

  localparam int POS_W_DEFAULT = 3;

endpackage : scan_pkg

// File: rtl/pos_bound_cmp.sv
// Boundary detector: flags when pos is at or beyond either end of the scan range.
// Latency: combinational, zero cycles.
// Backpressure: none; pure function of pos.
module pos_bound_cmp #(
  parameter int POS_W   = 3,
  parameter int MIN_POS = 0,
  parameter int MAX_POS = 7
) (
  input  logic [POS_W-1:0] pos,
  output logic             at_min,
  output logic             at_max
);

  localparam logic [POS_W-1:0] MIN_V = POS_W'(MIN_POS);
  localparam logic [POS_W-1:0] MAX_V = POS_W'(MAX_POS);

  // Unsigned saturating compares so positions outside the range still count as the boundary.
  always_comb begin
    at_min = (pos <= MIN_V);
    at_max = (pos >= MAX_V);
  end

endmodule : pos_bound_cmp

// File: rtl/two_state_fsm.sv
// Direction controller for a bouncing scanner: flips dir when pos hits an end of range.
// Latency: dir and turn change one clock after pos reaches a boundary (registered Moore outputs).
// Backpressure: none; pos is sampled every clock.
module two_state_fsm
  import scan_pkg::*;
#(
  parameter int POS_W   = POS_W_DEFAULT,
  parameter int MIN_POS = 0,
  parameter int MAX_POS = 2**POS_W - 1
) (
  input  logic             clk,
  input  logic             arst,
  input  logic [POS_W-1:0] pos,
  output logic             dir,
  output logic             turn
);

  // Reject illegal ranges while elaborating; both ends must fit in pos and be strictly ordered.
  if (POS_W < 1 || MIN_POS < 0 || MAX_POS > 2**POS_W - 1 || MIN_POS >= MAX_POS) begin : g_param_err
    $fatal(1, "two_state_fsm: illegal range POS_W=%0d MIN_POS=%0d MAX_POS=%0d",
           POS_W, MIN_POS, MAX_POS);
  end

  dir_e state_q;
  dir_e state_d;
  logic turn_q;
  logic at_min;
  logic at_max;

  pos_bound_cmp #(
    .POS_W  (POS_W),
    .MIN_POS(MIN_POS),
    .MAX_POS(MAX_POS)
  ) u_bound (
    .pos   (pos),
    .at_min(at_min),
    .at_max(at_max)
  );

  // Next direction: turn around at the far end; an unknown state falls back to RIGHT.
  always_comb begin
    state_d = state_q;
    case (state_q)
      DIR_RIGHT: if (at_max) state_d = DIR_LEFT;
      DIR_LEFT:  if (at_min) state_d = DIR_RIGHT;
      default:   state_d = DIR_RIGHT;
    endcase
  end

  // State register; reset parks the scanner heading RIGHT.
  always_ff @(posedge clk or negedge arst) begin
    if (!arst) begin
      state_q <= DIR_RIGHT;
    end else begin
      state_q <= state_d;
    end
  end

  // Turn pulse: high for exactly the cycle after the direction changed.
  always_ff @(posedge clk or negedge arst) begin
    if (!arst) begin
      turn_q <= 1'b0;
    end else begin
      turn_q <= (state_d != state_q);
    end
  end

  assign dir  = state_q;
  assign turn = turn_q;

endmodule : two_state_fsm

// File: tb/tb_two_state_fsm.sv
module tb_two_state_fsm;

  logic       clk;
  logic       arst_a;
  logic [2:0] pos_a;
  logic       dir_a;
  logic       turn_a;

  logic       arst_b;
  logic [2:0] pos_b;
  logic       dir_b;
  logic       turn_b;

  int errors;
  int checks;

  two_state_fsm #(.POS_W(3)) dut_a (
    .clk (clk),
    .arst(arst_a),
    .pos (pos_a),
    .dir (dir_a),
    .turn(turn_a)
  );

  two_state_fsm #(.POS_W(3), .MIN_POS(2), .MAX_POS(5)) dut_b (
    .clk (clk),
    .arst(arst_b),
    .pos (pos_b),
    .dir (dir_b),
    .turn(turn_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one rising edge and settle 1 time unit past it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    arst_a = 1'b0;
    pos_a  = 3'd0;
    step();
    checks++;
    if (dir_a !== 1'b1) begin
      errors++;
      $display("FAIL reset_dir: got %b want 1", dir_a);
    end
    checks++;
    if (turn_a !== 1'b0) begin
      errors++;
      $display("FAIL reset_turn: got %b want 0", turn_a);
    end
    arst_a = 1'b1;
    step();
    checks++;
    if (dir_a !== 1'b1 || turn_a !== 1'b0) begin
      errors++;
      $display("FAIL post_reset_pos0: dir=%b turn=%b want dir=1 turn=0", dir_a, turn_a);
    end
  endtask

  task automatic test_hit_max();
    pos_a = 3'd7;
    step();
    checks++;
    if (dir_a !== 1'b0 || turn_a !== 1'b1) begin
      errors++;
      $display("FAIL hit_max: dir=%b turn=%b want dir=0 turn=1", dir_a, turn_a);
    end
    step();
    checks++;
    if (dir_a !== 1'b0 || turn_a !== 1'b0) begin
      errors++;
      $display("FAIL hold_max: dir=%b turn=%b want dir=0 turn=0", dir_a, turn_a);
    end
  endtask

  task automatic test_hit_min();
    pos_a = 3'd0;
    step();
    checks++;
    if (dir_a !== 1'b1 || turn_a !== 1'b1) begin
      errors++;
      $display("FAIL hit_min: dir=%b turn=%b want dir=1 turn=1", dir_a, turn_a);
    end
    step();
    checks++;
    if (dir_a !== 1'b1 || turn_a !== 1'b0) begin
      errors++;
      $display("FAIL hold_min: dir=%b turn=%b want dir=1 turn=0", dir_a, turn_a);
    end
  endtask

  task automatic test_sweep();
    for (int p = 0; p <= 6; p++) begin
      pos_a = 3'(p);
      step();
      checks++;
      if (dir_a !== 1'b1 || turn_a !== 1'b0) begin
        errors++;
        $display("FAIL sweep_right pos=%0d: dir=%b turn=%b want dir=1 turn=0", p, dir_a, turn_a);
      end
    end
    pos_a = 3'd7;
    step();
    checks++;
    if (dir_a !== 1'b0 || turn_a !== 1'b1) begin
      errors++;
      $display("FAIL sweep_turn_left: dir=%b turn=%b want dir=0 turn=1", dir_a, turn_a);
    end
    for (int p = 6; p >= 1; p--) begin
      pos_a = 3'(p);
      step();
      checks++;
      if (dir_a !== 1'b0 || turn_a !== 1'b0) begin
        errors++;
        $display("FAIL sweep_left pos=%0d: dir=%b turn=%b want dir=0 turn=0", p, dir_a, turn_a);
      end
    end
  endtask

  task automatic test_async_reset();
    pos_a = 3'd3;
    step();
    checks++;
    if (dir_a !== 1'b0) begin
      errors++;
      $display("FAIL pre_async_left: dir=%b want 0", dir_a);
    end
    #2;
    arst_a = 1'b0;
    #1;
    checks++;
    if (dir_a !== 1'b1 || turn_a !== 1'b0) begin
      errors++;
      $display("FAIL async_reset: dir=%b turn=%b want dir=1 turn=0", dir_a, turn_a);
    end
    #1;
    arst_a = 1'b1;
    step();
    checks++;
    if (dir_a !== 1'b1 || turn_a !== 1'b0) begin
      errors++;
      $display("FAIL after_async_release: dir=%b turn=%b want dir=1 turn=0", dir_a, turn_a);
    end
  endtask

  task automatic test_back_to_back();
    logic [2:0] seq [4];
    logic       exp_dir [4];
    seq[0] = 3'd7; exp_dir[0] = 1'b0;
    seq[1] = 3'd0; exp_dir[1] = 1'b1;
    seq[2] = 3'd7; exp_dir[2] = 1'b0;
    seq[3] = 3'd0; exp_dir[3] = 1'b1;
    for (int i = 0; i < 4; i++) begin
      pos_a = seq[i];
      step();
      checks++;
      if (dir_a !== exp_dir[i] || turn_a !== 1'b1) begin
        errors++;
        $display("FAIL back_to_back[%0d]: dir=%b turn=%b want dir=%b turn=1",
                 i, dir_a, turn_a, exp_dir[i]);
      end
    end
  endtask

  task automatic test_custom_range();
    logic [2:0] seq [8];
    logic       exp_dir [8];
    logic       exp_turn [8];
    // pos: stay, saturate high, MAX in LEFT, mid, saturate low, MIN in RIGHT, exact MAX, exact MIN
    seq[0] = 3'd4; exp_dir[0] = 1'b1; exp_turn[0] = 1'b0;
    seq[1] = 3'd6; exp_dir[1] = 1'b0; exp_turn[1] = 1'b1;
    seq[2] = 3'd5; exp_dir[2] = 1'b0; exp_turn[2] = 1'b0;
    seq[3] = 3'd3; exp_dir[3] = 1'b0; exp_turn[3] = 1'b0;
    seq[4] = 3'd1; exp_dir[4] = 1'b1; exp_turn[4] = 1'b1;
    seq[5] = 3'd2; exp_dir[5] = 1'b1; exp_turn[5] = 1'b0;
    seq[6] = 3'd5; exp_dir[6] = 1'b0; exp_turn[6] = 1'b1;
    seq[7] = 3'd2; exp_dir[7] = 1'b1; exp_turn[7] = 1'b1;
    arst_b = 1'b0;
    pos_b  = 3'd0;
    step();
    checks++;
    if (dir_b !== 1'b1 || turn_b !== 1'b0) begin
      errors++;
      $display("FAIL custom_reset: dir=%b turn=%b want dir=1 turn=0", dir_b, turn_b);
    end
    arst_b = 1'b1;
    for (int i = 0; i < 8; i++) begin
      pos_b = seq[i];
      step();
      checks++;
      if (dir_b !== exp_dir[i] || turn_b !== exp_turn[i]) begin
        errors++;
        $display("FAIL custom[%0d] pos=%0d: dir=%b turn=%b want dir=%b turn=%b",
                 i, seq[i], dir_b, turn_b, exp_dir[i], exp_turn[i]);
      end
    end
  endtask

  initial begin
    errors = 0;
    checks = 0;
    arst_a = 1'b0;
    arst_b = 1'b0;
    pos_a  = 3'd0;
    pos_b  = 3'd0;
    #1;
    test_reset();
    test_hit_max();
    test_hit_min();
    test_sweep();
    test_async_reset();
    test_back_to_back();
    test_custom_range();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule : tb_two_state_fsm
